// File: rtl/chan4_pkg.sv
// chan4_pkg
// Shared definitions for the 4-channel deserializer slice.
//   NUM_CHAN      number of demux channels
//   CHAN_W        width of a channel index
//   DEFAULT_WIDTH default bits per assembled word
//   chan_t        channel-index type
package chan4_pkg;
  localparam int NUM_CHAN      = 4;
  localparam int CHAN_W        = 2;
  localparam int DEFAULT_WIDTH = 4;

  typedef logic [CHAN_W-1:0] chan_t;
endpackage

// File: rtl/chan4_lane_shifter.sv
// chan4_lane_shifter
// One channel of the deserializer: LSB-first shift register, bit counter,
// single-word holding register and its pending flag.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   shift_en     accept bit_in on this edge
//   bit_in       serial bit for this channel
//   load         output stage takes hold_data on this edge
//   pending      hold_data contains an unconsumed word
//   hold_data    last completed word
//   drop         a completed word is being discarded on this edge
module chan4_lane_shifter
  import chan4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             shift_en,
  input  logic             bit_in,
  input  logic             load,
  output logic             pending,
  output logic [WIDTH-1:0] hold_data,
  output logic             drop
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [WIDTH-2:0] sr;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] word_next;
  logic             last_bit;
  logic             complete;

  // Bits enter at the top and move down, so after WIDTH shifts the first
  // accepted bit sits in bit 0. word_next is the word as it would be if this
  // were the final bit.
  assign word_next = {bit_in, sr};
  assign last_bit  = (cnt == CNT_W'(WIDTH - 1));
  assign complete  = shift_en && last_bit;
  // A held word being loaded this edge frees the slot for the new one.
  assign drop      = complete && pending && !load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr        <= '0;
      cnt       <= '0;
      hold_data <= '0;
      pending   <= 1'b0;
    end else begin
      if (shift_en) begin
        sr  <= word_next[WIDTH-1:1];
        cnt <= last_bit ? '0 : cnt + 1'b1;
      end
      if (complete && (!pending || load)) begin
        hold_data <= word_next;
        pending   <= 1'b1;
      end else if (load) begin
        pending <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/chan4_deserializer.sv
// chan4_deserializer
// Reassembles WIDTH-bit words from a 4-way bit demux. Each channel builds its
// word LSB first; completed words wait in a per-channel holding register and
// are moved round-robin into a single valid/ready output register.
// Optional feature: define CHAN4_DESER_PARITY_EN to add out_parity
// (odd parity of out_data, registered alongside it, reset value 1).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           accept lane[sel] on this edge
//   sel          channel the current bit belongs to
//   lane         demux lanes, only lane[sel] is sampled
//   out_valid    out_data/out_chan hold a word
//   out_ready    consumer accepts the word
//   out_data     assembled word
//   out_chan     channel of out_data
//   ovf          sticky per-channel overflow flags
//   out_parity   (CHAN4_DESER_PARITY_EN only) odd parity of out_data
module chan4_deserializer
  import chan4_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       sel,
  input  logic [3:0]       lane,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [1:0]       out_chan,
  output logic [3:0]       ovf
`ifdef CHAN4_DESER_PARITY_EN
  ,
  output logic             out_parity
`endif
);

`ifdef CHAN4_DESER_PARITY_EN
  function automatic logic odd_parity(input logic [WIDTH-1:0] d);
    return ~(^d);
  endfunction
`endif

  logic [NUM_CHAN-1:0] pending;
  logic [NUM_CHAN-1:0] drop;
  logic [NUM_CHAN-1:0] load_ch;
  logic [WIDTH-1:0]    hold_data [NUM_CHAN];

  chan_t last_ch;
  chan_t grant_ch;
  chan_t cand;
  logic  grant_vld;
  logic  load_ok;

  for (genvar g = 0; g < NUM_CHAN; g++) begin : g_lane
    chan4_lane_shifter #(.WIDTH(WIDTH)) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .shift_en (en && (sel == chan_t'(g))),
      .bit_in   (lane[g]),
      .load     (load_ch[g]),
      .pending  (pending[g]),
      .hold_data(hold_data[g]),
      .drop     (drop[g])
    );
  end

  // Round-robin search begins one past the last granted channel; the
  // i == NUM_CHAN step wraps back to last_ch itself so it is considered last.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = last_ch;
    cand      = '0;
    load_ch   = '0;
    load_ok   = !out_valid || out_ready;
    for (int i = 1; i <= NUM_CHAN; i++) begin
      cand = last_ch + chan_t'(i);
      if (!grant_vld && pending[cand]) begin
        grant_vld = 1'b1;
        grant_ch  = cand;
      end
    end
    if (!load_ok) begin
      grant_vld = 1'b0;
    end
    if (grant_vld) begin
      load_ch[grant_ch] = 1'b1;
    end
  end

  // Output stage: loads on empty or transfer, otherwise holds its word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_chan   <= '0;
      // Last grant = highest channel so channel 0 is searched first.
      last_ch    <= chan_t'(NUM_CHAN - 1);
      ovf        <= '0;
`ifdef CHAN4_DESER_PARITY_EN
      out_parity <= 1'b1;
`endif
    end else begin
      ovf <= ovf | drop;
      if (grant_vld) begin
        out_valid  <= 1'b1;
        out_data   <= hold_data[grant_ch];
        out_chan   <= grant_ch;
        last_ch    <= grant_ch;
`ifdef CHAN4_DESER_PARITY_EN
        out_parity <= odd_parity(hold_data[grant_ch]);
`endif
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chan4_deserializer.sv
module tb_chan4_deserializer;
  localparam int WIDTH = 4;

  logic             clk;
  logic             rst_n;
  logic             en;
  logic [1:0]       sel;
  logic [3:0]       lane;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [1:0]       out_chan;
  logic [3:0]       ovf;
`ifdef CHAN4_DESER_PARITY_EN
  logic             out_parity;
`endif

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  logic [WIDTH-1:0] mon_data [$];
  logic [1:0]       mon_chan [$];
  int               mon_cyc  [$];

  chan4_deserializer #(.WIDTH(WIDTH)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .sel      (sel),
    .lane     (lane),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_chan (out_chan),
    .ovf      (ovf)
`ifdef CHAN4_DESER_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every transfer; inputs change just after posedge, so at negedge
  // out_ready already holds the value for the coming edge.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      mon_data.push_back(out_data);
      mon_chan.push_back(out_chan);
      mon_cyc.push_back(cyc);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    mon_data.delete();
    mon_chan.delete();
    mon_cyc.delete();
  endtask

  task automatic send_bit(input int ch, input logic b);
    lane     = {4{~b}};
    lane[ch] = b;
    sel      = 2'(ch);
    en       = 1'b1;
    @(posedge clk);
    #1;
    en   = 1'b0;
    lane = '0;
  endtask

  task automatic send_word(input int ch, input logic [WIDTH-1:0] w);
    for (int i = 0; i < WIDTH; i++) send_bit(ch, w[i]);
  endtask

  task automatic do_reset();
    en        = 1'b0;
    sel       = '0;
    lane      = '0;
    out_ready = 1'b0;
    rst_n     = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    clear_mon();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== 2'd0 || ovf !== 4'd0) begin
      errors++;
      $display("FAIL reset_state: valid=%b data=%h chan=%0d ovf=%b, want 0/0/0/0",
               out_valid, out_data, out_chan, ovf);
    end
  endtask

  task automatic test_basic();
    do_reset();
    out_ready = 1'b1;
    send_bit(2, 1'b1);
    send_bit(2, 1'b0);
    send_bit(2, 1'b1);
    send_bit(2, 1'b1);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL basic_latency_early: out_valid=%b, want 0", out_valid);
    end
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'hD || out_chan !== 2'd2) begin
      errors++;
      $display("FAIL basic_word: valid=%b data=%h chan=%0d, want 1/d/2",
               out_valid, out_data, out_chan);
    end
    idle(3);
    checks++;
    if (mon_data.size() !== 1 || out_valid !== 1'b0 || ovf !== 4'd0) begin
      errors++;
      $display("FAIL basic_single: transfers=%0d valid=%b ovf=%b, want 1/0/0000",
               mon_data.size(), out_valid, ovf);
    end
  endtask

  task automatic test_enable();
    do_reset();
    out_ready = 1'b1;
    sel  = 2'd1;
    lane = 4'hF;
    en   = 1'b0;
    idle(8);
    lane = '0;
    checks++;
    if (mon_data.size() !== 0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL enable_off: transfers=%0d valid=%b, want 0/0", mon_data.size(), out_valid);
    end
    send_word(1, 4'h6);
    idle(3);
    checks++;
    if (mon_data.size() !== 1) begin
      errors++;
      $display("FAIL enable_count: transfers=%0d, want 1", mon_data.size());
    end else if (mon_data[0] !== 4'h6 || mon_chan[0] !== 2'd1) begin
      errors++;
      $display("FAIL enable_word: data=%h chan=%0d, want 6/1", mon_data[0], mon_chan[0]);
    end
  endtask

  task automatic test_interleave();
    logic [3:0] b0;
    logic [3:0] b3;
    do_reset();
    out_ready = 1'b1;
    b0 = 4'b1111;
    b3 = 4'b0010;
    for (int i = 0; i < 4; i++) begin
      send_bit(0, b0[i]);
      send_bit(3, b3[i]);
    end
    idle(4);
    checks++;
    if (mon_data.size() !== 2) begin
      errors++;
      $display("FAIL interleave_count: transfers=%0d, want 2", mon_data.size());
    end else begin
      checks++;
      if (mon_data[0] !== 4'hF || mon_chan[0] !== 2'd0) begin
        errors++;
        $display("FAIL interleave_ch0: data=%h chan=%0d, want f/0", mon_data[0], mon_chan[0]);
      end
      checks++;
      if (mon_data[1] !== 4'h2 || mon_chan[1] !== 2'd3) begin
        errors++;
        $display("FAIL interleave_ch3: data=%h chan=%0d, want 2/3", mon_data[1], mon_chan[1]);
      end
    end
  endtask

  task automatic rr_burst(input logic [WIDTH-1:0] w0, input logic [WIDTH-1:0] w1,
                          input logic [WIDTH-1:0] w2, input logic [WIDTH-1:0] w3,
                          input string tag);
    logic [WIDTH-1:0] w [4];
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    clear_mon();
    out_ready = 1'b0;
    for (int i = 0; i < WIDTH; i++)
      for (int c = 0; c < 4; c++) send_bit(c, w[c][i]);
    out_ready = 1'b1;
    idle(6);
    out_ready = 1'b0;
    checks++;
    if (mon_data.size() !== 4) begin
      errors++;
      $display("FAIL rr_%s_count: transfers=%0d, want 4", tag, mon_data.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        checks++;
        if (mon_chan[k] !== 2'(k) || mon_data[k] !== w[k] || mon_cyc[k] !== mon_cyc[0] + k) begin
          errors++;
          $display("FAIL rr_%s_%0d: chan=%0d data=%h cyc+%0d, want %0d/%h/+%0d",
                   tag, k, mon_chan[k], mon_data[k], mon_cyc[k] - mon_cyc[0], k, w[k], k);
        end
      end
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    rr_burst(4'h1, 4'h2, 4'h4, 4'h8, "first");
    rr_burst(4'h3, 4'h5, 4'h6, 4'h9, "second");
  endtask

  task automatic test_overflow();
    do_reset();
    out_ready = 1'b0;
    send_word(1, 4'hA);
    send_word(1, 4'h5);
    checks++;
    if (ovf !== 4'b0000) begin
      errors++;
      $display("FAIL ovf_early: ovf=%b, want 0000", ovf);
    end
    send_word(1, 4'h3);
    checks++;
    if (ovf !== 4'b0010 || out_data !== 4'hA || out_chan !== 2'd1 || out_valid !== 1'b1) begin
      errors++;
      $display("FAIL ovf_set: ovf=%b data=%h chan=%0d valid=%b, want 0010/a/1/1",
               ovf, out_data, out_chan, out_valid);
    end
    out_ready = 1'b1;
    idle(4);
    checks++;
    if (mon_data.size() !== 2) begin
      errors++;
      $display("FAIL ovf_count: transfers=%0d, want 2", mon_data.size());
    end else if (mon_data[0] !== 4'hA || mon_data[1] !== 4'h5) begin
      errors++;
      $display("FAIL ovf_words: got %h,%h, want a,5", mon_data[0], mon_data[1]);
    end
    checks++;
    if (ovf !== 4'b0010) begin
      errors++;
      $display("FAIL ovf_sticky: ovf=%b, want 0010", ovf);
    end
  endtask

  // Runs straight after test_overflow so ovf is still set going into reset.
  task automatic test_reset_mid_word();
    out_ready = 1'b0;
    send_word(3, 4'hF);
    send_bit(0, 1'b1);
    send_bit(0, 1'b1);
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_pre: out_valid=%b, want 1", out_valid);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_chan !== 2'd0 || ovf !== 4'd0) begin
      errors++;
      $display("FAIL rstmid_async: valid=%b data=%h chan=%0d ovf=%b, want 0/0/0/0000",
               out_valid, out_data, out_chan, ovf);
    end
`ifdef CHAN4_DESER_PARITY_EN
    checks++;
    if (out_parity !== 1'b1) begin
      errors++;
      $display("FAIL rstmid_parity: out_parity=%b, want 1", out_parity);
    end
`endif
    idle(1);
    rst_n = 1'b1;
    idle(1);
    clear_mon();
    out_ready = 1'b1;
    send_word(0, 4'h4);
    idle(3);
    checks++;
    if (mon_data.size() !== 1) begin
      errors++;
      $display("FAIL rstmid_count: transfers=%0d, want 1", mon_data.size());
    end else if (mon_data[0] !== 4'h4 || mon_chan[0] !== 2'd0) begin
      errors++;
      $display("FAIL rstmid_word: data=%h chan=%0d, want 4/0", mon_data[0], mon_chan[0]);
    end
  endtask

`ifdef CHAN4_DESER_PARITY_EN
  task automatic test_parity();
    do_reset();
    checks++;
    if (out_parity !== 1'b1) begin
      errors++;
      $display("FAIL parity_reset: out_parity=%b, want 1", out_parity);
    end
    out_ready = 1'b0;
    send_word(0, 4'h7);
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h7 || out_parity !== 1'b0) begin
      errors++;
      $display("FAIL parity_7: valid=%b data=%h parity=%b, want 1/7/0",
               out_valid, out_data, out_parity);
    end
    out_ready = 1'b1;
    idle(1);
    out_ready = 1'b0;
    send_word(2, 4'h3);
    idle(1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 4'h3 || out_parity !== 1'b1) begin
      errors++;
      $display("FAIL parity_3: valid=%b data=%h parity=%b, want 1/3/1",
               out_valid, out_data, out_parity);
    end
  endtask
`endif

  initial begin
    rst_n     = 1'b0;
    en        = 1'b0;
    sel       = '0;
    lane      = '0;
    out_ready = 1'b0;
    test_reset();
    test_basic();
    test_enable();
    test_interleave();
    test_round_robin();
    test_overflow();
    test_reset_mid_word();
`ifdef CHAN4_DESER_PARITY_EN
    test_parity();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
